matrix_multiply_unit: RTL and testbench
=======================================

# matrix_multiply_unit

Output-stationary systolic array that multiplies two LENGTH×LENGTH unsigned matrices, A×B. Rows of A enter on the left edge and columns of B enter on the top edge, both pre-skewed by the caller. Each processing element (PE) accumulates one element of the product in place. The block is the compute core of the accelerator datapath, fed by the input/weight staging logic, with its results read in parallel.

## Interface
- WIDTH, 8: bit width of each A/B element (unsigned).
- LENGTH, 3: array dimension; the array holds LENGTH×LENGTH PEs.

- CLK  in  1  single clock; all state updates on the rising edge.
- SYNC_RST  in  1  synchronous, active-high reset. Clears all PE state on the next rising edge.
- ASYNC_RST  in  1  retained for pin compatibility only; no functional effect; tie high.
- EN  in  1  global advance/accumulate enable.
- Inputs[0:LENGTH-1]  in  WIDTH each  left-edge feed; Inputs[i] drives PE row i.
- Weights[0:LENGTH-1]  in  WIDTH each  top-edge feed; Weights[j] drives PE column j.
- Result[0:LENGTH-1][0:LENGTH-1]  out  2*WIDTH each  accumulator of PE(i,j), registered.

## Operation
- PE(i,j) has three registers:
  - a_reg (WIDTH): operand forwarded right.
  - b_reg (WIDTH): operand forwarded down.
  - acc (2*WIDTH): running product sum.
- PE operand sources:
  - a_in = Inputs[i] when j=0, else a_reg of PE(i,j-1).
  - b_in = Weights[j] when i=0, else b_reg of PE(i-1,j).
- On a rising edge with SYNC_RST=1: all a_reg, b_reg and acc are set to 0. Reset has priority over EN.
- On a rising edge with EN=1 and SYNC_RST=0:
  - acc <= acc + a_in*b_in.
  - a_reg <= a_in.
  - b_reg <= b_in.
- On a rising edge with EN=0: all registers hold.
- Arithmetic:
  - Operands are unsigned; the product is full 2*WIDTH.
  - The accumulator wraps modulo 2^(2*WIDTH); there is no saturation and no overflow flag.
- Result[i][j] = acc of PE(i,j) directly. There is no output mux.
- Accumulators are never cleared implicitly. Starting a new matrix product requires SYNC_RST, or the caller feeds zeros and accepts accumulation.
- Zero operands contribute nothing, so the caller pads the skew with zeros.
- Required feed format: at feed step s = 1..2*LENGTH-1 (one step per enabled edge):
  - Inputs[i] = A[i][s-i-1] when 0 ≤ s-i-1 < LENGTH, else 0.
  - Weights[j] = B[s-j-1][j] when 0 ≤ s-j-1 < LENGTH, else 0.
  - After the last step, all feeds are driven to 0.

## Timing
- Reset value of every output: Result = 0 for all i,j.
- Element k of a dot product reaches PE(i,j) on enabled edge i+j+k+1, counting from the edge that samples feed step 1.
- Latency: Result[i][j] is final after enabled edge i+j+LENGTH. The full matrix is valid after 3*LENGTH-2 enabled edges (7 for LENGTH=3).
- Results remain stable afterwards as long as the feeds stay 0, or EN=0.
- Stall: deasserting EN freezes the wavefront. Timing counts enabled edges only, and the result is unchanged by stalls.
- Reset mid-operation: all accumulators and in-flight operands are zeroed on that edge. The partial computation is lost and the feed must restart at step 1.
- Simultaneous SYNC_RST and EN: reset wins.

## Structure
- Shared package: element type (logic [WIDTH-1:0]) and accumulator type (logic [2*WIDTH-1:0]) as parameterized typedef helpers, plus default WIDTH/LENGTH constants.
- One sub-module, mmu_pe:
  - Ports: CLK, SYNC_RST, EN, a_in, b_in, a_out, b_out, acc.
  - The top level instantiates LENGTH×LENGTH copies in a generate grid and wires the edges to Inputs/Weights.

## Test plan
- Reset: hold SYNC_RST=1 for 2 edges with random feeds. Every Result must read 0, and must still read 0 one edge after release while feeds are 0.
- Reference product: WIDTH=8, LENGTH=3, A={{4,3,7},{4,4,7},{6,8,2}}, B={{9,4,5},{10,4,5},{7,4,7}}, skewed feed, EN=1. After 7 edges Result must be {{115,56,84},{125,60,89},{148,64,84}}, and it must hold for 2 further edges with zero feeds.
- Identity: A = identity, B = the B above. Result must equal B exactly after 7 edges.
- Stall: same as the reference product, but EN=0 for 3 random cycles mid-feed (feeds held). Result must be identical after 7 enabled edges, and no register may change while EN=0.
- Overflow: A and B all 255. Each Result must be 3*65025 mod 65536 = 64003.
- Reset mid-run: assert SYNC_RST at edge 4 of the reference run. All Result must be 0 the next cycle. A restarted full feed must then yield the reference values.

Source files
------------

// File: rtl/matrix_multiply_unit_pkg.sv
// Shared definitions for the matrix multiply unit: default geometry and
// element/accumulator types sized from the default element width.
package matrix_multiply_unit_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_LENGTH = 3;

  // Accumulator width is twice the operand width so a single full product fits.
  localparam int DEFAULT_ACC_WIDTH = 2 * DEFAULT_WIDTH;

  typedef logic [DEFAULT_WIDTH-1:0]     elem_t;
  typedef logic [DEFAULT_ACC_WIDTH-1:0] acc_t;

endpackage : matrix_multiply_unit_pkg

// File: rtl/matrix_multiply_unit_pe.sv
// Processing element of the output-stationary systolic array. It forwards
// its A operand right and its B operand down, and accumulates their product
// in place. The accumulator wraps silently on overflow.
module mmu_pe
  import matrix_multiply_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               CLK,
  input  logic               SYNC_RST,
  input  logic               EN,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] product;

  // Zero-extend both operands so the multiply is carried out at full width.
  assign product = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};

  // Operand pipeline and accumulator; reset beats enable, EN=0 freezes all.
  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else if (EN) begin
      a_reg   <= a_in;
      b_reg   <= b_in;
      acc_reg <= acc_reg + product;
    end
  end

  assign a_out = a_reg;
  assign b_out = b_reg;
  assign acc   = acc_reg;

endmodule : mmu_pe

// File: rtl/matrix_multiply_unit.sv
// Output-stationary LENGTH x LENGTH systolic multiplier. Rows of A enter on
// the left and columns of B on the top, both pre-skewed by the caller; each
// PE's accumulator is presented directly on Result.
module matrix_multiply_unit
  import matrix_multiply_unit_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int LENGTH = DEFAULT_LENGTH
) (
  input  logic               CLK,
  input  logic               SYNC_RST,
  input  logic               ASYNC_RST,
  input  logic               EN,
  input  logic [WIDTH-1:0]   Inputs  [0:LENGTH-1],
  input  logic [WIDTH-1:0]   Weights [0:LENGTH-1],
  output logic [2*WIDTH-1:0] Result  [0:LENGTH-1][0:LENGTH-1]
);

  // a_bus[i][j] is the A operand entering PE(i,j); column LENGTH is the
  // right-edge spill. b_bus[i][j] likewise for B, with row LENGTH the
  // bottom-edge spill.
  logic [WIDTH-1:0] a_bus [0:LENGTH-1][0:LENGTH];
  logic [WIDTH-1:0] b_bus [0:LENGTH][0:LENGTH-1];

  // Kept only for pin compatibility; it has no functional effect.
  logic unused_async_rst;
  assign unused_async_rst = ASYNC_RST;

  // Operands leaving the far edges of the array are dropped.
  logic [LENGTH-1:0] unused_a_edge;
  logic [LENGTH-1:0] unused_b_edge;

  genvar gi, gj;
  generate
    for (gi = 0; gi < LENGTH; gi++) begin : g_edge
      assign a_bus[gi][0]      = Inputs[gi];
      assign b_bus[0][gi]      = Weights[gi];
      assign unused_a_edge[gi] = ^a_bus[gi][LENGTH];
      assign unused_b_edge[gi] = ^b_bus[LENGTH][gi];
    end

    for (gi = 0; gi < LENGTH; gi++) begin : g_row
      for (gj = 0; gj < LENGTH; gj++) begin : g_col
        mmu_pe #(
          .WIDTH (WIDTH)
        ) u_pe (
          .CLK      (CLK),
          .SYNC_RST (SYNC_RST),
          .EN       (EN),
          .a_in     (a_bus[gi][gj]),
          .b_in     (b_bus[gi][gj]),
          .a_out    (a_bus[gi][gj+1]),
          .b_out    (b_bus[gi+1][gj]),
          .acc      (Result[gi][gj])
        );
      end
    end
  endgenerate

endmodule : matrix_multiply_unit

// File: tb/tb_matrix_multiply_unit.sv
// Self-checking bench for matrix_multiply_unit: directed scenarios plus
// randomized matrices with random stalls, against a plain matrix-product model.
module tb_matrix_multiply_unit;

  localparam int W = 8;
  localparam int L = 3;
  localparam int EDGES = 3 * L - 2;

  typedef int mat_t [0:L-1][0:L-1];

  logic           CLK = 1'b0;
  logic           SYNC_RST;
  logic           ASYNC_RST;
  logic           EN;
  logic [W-1:0]   Inputs  [0:L-1];
  logic [W-1:0]   Weights [0:L-1];
  logic [2*W-1:0] Result  [0:L-1][0:L-1];

  int cmp_count = 0;
  int err_count = 0;

  mat_t ref_a, ref_b, ref_c, ident, ones;

  matrix_multiply_unit #(.WIDTH(W), .LENGTH(L)) dut (
    .CLK       (CLK),
    .SYNC_RST  (SYNC_RST),
    .ASYNC_RST (ASYNC_RST),
    .EN        (EN),
    .Inputs    (Inputs),
    .Weights   (Weights),
    .Result    (Result)
  );

  always #5 CLK = ~CLK;

  // Reference: ordinary matrix product reduced modulo 2^(2W).
  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t c;
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        longint sum = 0;
        for (int k = 0; k < L; k++) sum += longint'(a[i][k]) * longint'(b[k][j]);
        c[i][j] = int'(sum % 65536);
      end
    return c;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) m[i][j] = int'($urandom_range(0, 255));
    return m;
  endfunction

  // Drive the skewed feed for step s (steps outside 1..2L-1 give zeros).
  task automatic feed_step(input mat_t a, input mat_t b, input int s);
    for (int i = 0; i < L; i++) begin
      int k = s - i - 1;
      Inputs[i]  = (k >= 0 && k < L) ? W'(a[i][k]) : '0;
      Weights[i] = (k >= 0 && k < L) ? W'(b[k][i]) : '0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    SYNC_RST = 1'b1;
    EN = 1'b0;
    feed_step(ref_a, ref_b, 0);
    tick();
    SYNC_RST = 1'b0;
  endtask

  // Run a full skewed feed with EN=1 for the whole latency.
  task automatic run_full(input mat_t a, input mat_t b);
    for (int e = 1; e <= EDGES; e++) begin
      feed_step(a, b, e);
      EN = 1'b1;
      tick();
    end
    feed_step(a, b, 0);
  endtask

  task automatic test_reset();
    SYNC_RST = 1'b1;
    repeat (2) begin
      for (int i = 0; i < L; i++) begin
        Inputs[i]  = W'($urandom);
        Weights[i] = W'($urandom);
      end
      EN = 1'($urandom);
      tick();
    end
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        cmp_count++;
        if (Result[i][j] !== 16'd0) begin
          err_count++;
          $display("FAIL reset_hold r[%0d][%0d] got %0d expected 0", i, j, Result[i][j]);
        end
      end
    SYNC_RST = 1'b0;
    feed_step(ref_a, ref_b, 0);
    EN = 1'b1;
    tick();
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        cmp_count++;
        if (Result[i][j] !== 16'd0) begin
          err_count++;
          $display("FAIL reset_release r[%0d][%0d] got %0d expected 0", i, j, Result[i][j]);
        end
      end
    $display("test_reset: done, %0d errors so far", err_count);
  endtask

  task automatic test_reference();
    int exp_tab [0:L-1][0:L-1];
    exp_tab = '{'{115, 56, 84}, '{125, 60, 89}, '{148, 64, 84}};
    do_reset();
    run_full(ref_a, ref_b);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        cmp_count++;
        if (Result[i][j] !== 16'(exp_tab[i][j])) begin
          err_count++;
          $display("FAIL reference r[%0d][%0d] got %0d expected %0d", i, j, Result[i][j], exp_tab[i][j]);
        end
      end
    repeat (2) tick();
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        cmp_count++;
        if (Result[i][j] !== 16'(exp_tab[i][j])) begin
          err_count++;
          $display("FAIL reference_hold r[%0d][%0d] got %0d expected %0d", i, j, Result[i][j], exp_tab[i][j]);
        end
      end
    $display("test_reference: done, %0d errors so far", err_count);
  endtask

  task automatic test_identity();
    do_reset();
    run_full(ident, ref_b);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        cmp_count++;
        if (Result[i][j] !== 16'(ref_b[i][j])) begin
          err_count++;
          $display("FAIL identity r[%0d][%0d] got %0d expected %0d", i, j, Result[i][j], ref_b[i][j]);
        end
      end
    $display("test_identity: done, %0d errors so far", err_count);
  endtask

  task automatic test_stall();
    int stall_at;
    logic [2*W-1:0] snap [0:L-1][0:L-1];
    stall_at = int'($urandom_range(2, 5));
    do_reset();
    for (int e = 1; e <= EDGES; e++) begin
      feed_step(ref_a, ref_b, e);
      if (e == stall_at) begin
        snap = Result;
        EN = 1'b0;
        repeat (3) begin
          tick();
          for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++) begin
              cmp_count++;
              if (Result[i][j] !== snap[i][j]) begin
                err_count++;
                $display("FAIL stall_freeze r[%0d][%0d] got %0d expected %0d", i, j, Result[i][j], snap[i][j]);
              end
            end
        end
      end
      EN = 1'b1;
      tick();
    end
    feed_step(ref_a, ref_b, 0);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        cmp_count++;
        if (Result[i][j] !== 16'(ref_c[i][j])) begin
          err_count++;
          $display("FAIL stall_result r[%0d][%0d] got %0d expected %0d", i, j, Result[i][j], ref_c[i][j]);
        end
      end
    $display("test_stall: stall before edge %0d, %0d errors so far", stall_at, err_count);
  endtask

  task automatic test_overflow();
    do_reset();
    run_full(ones, ones);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        cmp_count++;
        if (Result[i][j] !== 16'd64003) begin
          err_count++;
          $display("FAIL overflow r[%0d][%0d] got %0d expected 64003", i, j, Result[i][j]);
        end
      end
    $display("test_overflow: done, %0d errors so far", err_count);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int e = 1; e <= 3; e++) begin
      feed_step(ref_a, ref_b, e);
      EN = 1'b1;
      tick();
    end
    feed_step(ref_a, ref_b, 4);
    SYNC_RST = 1'b1;
    EN = 1'b1;
    tick();
    SYNC_RST = 1'b0;
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        cmp_count++;
        if (Result[i][j] !== 16'd0) begin
          err_count++;
          $display("FAIL midreset_clear r[%0d][%0d] got %0d expected 0", i, j, Result[i][j]);
        end
      end
    run_full(ref_a, ref_b);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        cmp_count++;
        if (Result[i][j] !== 16'(ref_c[i][j])) begin
          err_count++;
          $display("FAIL midreset_restart r[%0d][%0d] got %0d expected %0d", i, j, Result[i][j], ref_c[i][j]);
        end
      end
    $display("test_reset_mid_run: done, %0d errors so far", err_count);
  endtask

  // Random matrices with random stalls; each element is checked from the
  // enabled edge on which it must be final (i+j+L) onward.
  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      mat_t a, b, c;
      int e, cyc;
      a = rand_mat();
      b = rand_mat();
      c = matmul(a, b);
      do_reset();
      e = 0;
      cyc = 0;
      while (e < EDGES && cyc < 200) begin
        feed_step(a, b, e + 1);
        EN = ($urandom_range(0, 3) != 0);
        tick();
        cyc++;
        if (EN) begin
          e++;
          for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++)
              if (i + j + L <= e) begin
                cmp_count++;
                if (Result[i][j] !== 16'(c[i][j])) begin
                  err_count++;
                  $display("FAIL random it%0d edge%0d r[%0d][%0d] got %0d expected %0d",
                           it, e, i, j, Result[i][j], c[i][j]);
                end
              end
        end
      end
      cmp_count++;
      if (e != EDGES) begin
        err_count++;
        $display("FAIL random_budget it%0d got %0d edges expected %0d", it, e, EDGES);
      end
      feed_step(a, b, 0);
      $display("test_random: iteration %0d took %0d cycles, %0d errors so far", it, cyc, err_count);
    end
  endtask

  initial begin
    ref_a = '{'{4, 3, 7}, '{4, 4, 7}, '{6, 8, 2}};
    ref_b = '{'{9, 4, 5}, '{10, 4, 5}, '{7, 4, 7}};
    ref_c = matmul(ref_a, ref_b);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        ident[i][j] = (i == j) ? 1 : 0;
        ones[i][j]  = 255;
      end
    ASYNC_RST = 1'b1;
    SYNC_RST  = 1'b1;
    EN        = 1'b0;
    feed_step(ref_a, ref_b, 0);
    tick();

    test_reset();
    test_reference();
    test_identity();
    test_stall();
    test_overflow();
    test_reset_mid_run();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule : tb_matrix_multiply_unit
